// File: rtl/fetch_decode_ctrl_pkg.sv
// Shared types and constants for the fetch/decode sequencer.
package fetch_decode_pkg;

  typedef enum logic [2:0] {
    RUN,
    LU,
    FLUSH,
    MEM_WAIT,
    HALT
  } state_t;

  localparam logic [15:0] NOP_OPCODE = 16'h0800;
  localparam logic [4:0]  RTI_OPCODE = 5'b00011;

  // Front-end control bundle, one bit per output.
  typedef struct packed {
    logic stall_decode;
    logic pc_hold;
    logic flush_fetch;
    logic nop_inject;
    logic halted;
  } ctrl_t;

endpackage

// File: rtl/fetch_decode_ctrl_if.sv
// Pipeline-side signal bundle for fetch_decode_ctrl.
// stall_cycles exists only when FETCH_DECODE_PERF_CNT_EN is defined.
interface fetch_decode_ctrl_if #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_halt;
  logic             ex_load;
  logic [REG_W-1:0] ex_rd;
  logic             ex_rti;
  logic             br_taken;
  logic             inst_stall;
  logic             d_stall;
  logic             stall_decode;
  logic             pc_hold;
  logic             flush_fetch;
  logic             nop_inject;
  logic             halted;
`ifdef FETCH_DECODE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles;
`endif

  if (REG_W < 1 || CNT_W < 1) begin : g_param_check
    $error("fetch_decode_ctrl_if: REG_W and CNT_W must be >= 1");
  end

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_halt, ex_load, ex_rd,
           ex_rti, br_taken, inst_stall, d_stall,
    input  stall_decode, pc_hold, flush_fetch, nop_inject, halted
`ifdef FETCH_DECODE_PERF_CNT_EN
    , input stall_cycles
`endif
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_halt, ex_load, ex_rd,
           ex_rti, br_taken, inst_stall, d_stall,
    output stall_decode, pc_hold, flush_fetch, nop_inject, halted
`ifdef FETCH_DECODE_PERF_CNT_EN
    , output stall_cycles
`endif
  );
endinterface

// File: rtl/fetch_decode_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID sources and the EX load destination.
module hazard_detect #(
  parameter int REG_W = 3
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_load,
  input  logic [REG_W-1:0] ex_rd,
  output logic             lu
);
  // Hazard when a load in EX writes a register the ID instruction reads.
  always_comb begin
    lu = ex_load & ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
  end
endmodule

// File: rtl/fetch_decode_ctrl.sv
// Front-end sequencer: load-use stalls, branch flushes, memory-stall holds, HALT.
// Optional stall counter enabled by FETCH_DECODE_PERF_CNT_EN.
module fetch_decode_ctrl
  import fetch_decode_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int REG_W        = 3,
  parameter int CNT_W        = 16
) (
  input logic               clk,
  input logic               rst,
  fetch_decode_ctrl_if.slave bus
);
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3 || CNT_W < 1) begin : g_param_check
    $error("fetch_decode_ctrl: FLUSH_CYCLES must be 1..3, CNT_W >= 1");
  end

  state_t     state, state_nxt;
  logic [1:0] flush_cnt, flush_cnt_nxt;
  logic       pend_br, pend_br_nxt;
  logic       lu, br_eff, lu_eff;
  ctrl_t      ctrl;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .id_rs     (bus.id_rs),
    .id_rt     (bus.id_rt),
    .id_use_rs (bus.id_use_rs),
    .id_use_rt (bus.id_use_rt),
    .ex_load   (bus.ex_load),
    .ex_rd     (bus.ex_rd),
    .lu        (lu)
  );

  // Output and next-state decode. RUN, LU and MEM_WAIT share one priority
  // chain: LU masks the (already serviced) hazard, MEM_WAIT folds a branch
  // that arrived during the memory stall back in as if it were taken now.
  always_comb begin
    ctrl          = '0;
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    pend_br_nxt   = 1'b0;
    br_eff        = bus.br_taken | pend_br;
    lu_eff        = lu & (state != LU);
    case (state)
      HALT: begin
        ctrl.stall_decode = 1'b1;
        ctrl.pc_hold      = 1'b1;
        ctrl.nop_inject   = 1'b1;
        ctrl.halted       = 1'b1;
      end
      FLUSH: begin
        ctrl.flush_fetch = 1'b1;
        ctrl.nop_inject  = 1'b1;
        if (bus.d_stall) begin
          ctrl.stall_decode = 1'b1;
          ctrl.pc_hold      = 1'b1;
        end else if (flush_cnt <= 2'd1) begin
          flush_cnt_nxt = '0;
          state_nxt     = RUN;
        end else begin
          flush_cnt_nxt = flush_cnt - 2'd1;
        end
      end
      default: begin
        state_nxt = RUN;
        if (bus.id_halt && !br_eff) begin
          state_nxt = HALT;
        end else if (bus.d_stall) begin
          ctrl.stall_decode = 1'b1;
          ctrl.pc_hold      = 1'b1;
          pend_br_nxt       = br_eff;
          state_nxt         = MEM_WAIT;
        end else if (br_eff) begin
          ctrl.flush_fetch = 1'b1;
          ctrl.nop_inject  = 1'b1;
          flush_cnt_nxt    = FLUSH_LOAD;
          state_nxt        = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (lu_eff) begin
          ctrl.stall_decode = 1'b1;
          ctrl.pc_hold      = 1'b1;
          ctrl.nop_inject   = 1'b1;
          state_nxt         = LU;
        end else if (bus.inst_stall) begin
          ctrl.pc_hold     = 1'b1;
          ctrl.flush_fetch = 1'b1;
        end
      end
    endcase
    if (bus.ex_rti && state != HALT) begin
      ctrl.flush_fetch = 1'b0;
      ctrl.nop_inject  = 1'b0;
    end
    if (rst) begin
      ctrl = '0;
    end
  end

  // Sequencer state; reset abandons any stall, flush or pending branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      flush_cnt <= '0;
      pend_br   <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      pend_br   <= pend_br_nxt;
    end
  end

  assign bus.stall_decode = ctrl.stall_decode;
  assign bus.pc_hold      = ctrl.pc_hold;
  assign bus.flush_fetch  = ctrl.flush_fetch;
  assign bus.nop_inject   = ctrl.nop_inject;
  assign bus.halted       = ctrl.halted;

`ifdef FETCH_DECODE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (ctrl.pc_hold && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.stall_cycles = stall_cnt;
`endif
endmodule
